// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet RX frame classifier.
package eth_pkg;

    typedef enum logic [2:0] {
        CLASS_OTHER      = 3'd0,
        CLASS_ARP        = 3'd1,
        CLASS_ICMP       = 3'd2,
        CLASS_UDP        = 3'd3,
        CLASS_IPV4_OTHER = 3'd4
    } eth_class_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } rx_state_e;

    localparam logic [15:0] ETHERTYPE_ARP    = 16'h0806;
    localparam logic [15:0] ETHERTYPE_IPV4   = 16'h0800;
    localparam logic [7:0]  IP_PROTO_ICMP    = 8'd1;
    localparam logic [7:0]  IP_PROTO_UDP     = 8'd17;
    localparam logic [47:0] BROADCAST_MAC    = 48'hffff_ffff_ffff;
    localparam logic [15:0] MIN_ARP_IP_BYTES = 16'd42;
    localparam logic [15:0] MIN_ETH_BYTES    = 16'd14;

endpackage

// File: rtl/eth_keep_decode.sv
// Decodes an AXI-Stream byte-enable: byte count and low-aligned contiguity.
module eth_keep_decode (
    input  logic [7:0] tkeep_i,
    output logic [3:0] popcount_o,
    output logic       contig_o
);

    // Count set enables; contiguous means 2^n-1 with n >= 1.
    always_comb begin
        popcount_o = 4'd0;
        for (int k = 0; k < 8; k++) begin
            popcount_o = popcount_o + {3'd0, tkeep_i[k]};
        end
        contig_o = (tkeep_i != 8'd0) && ((tkeep_i & (tkeep_i + 8'd1)) == 8'd0);
    end

endmodule

// File: rtl/eth_rx_frame_classifier.sv
// Parses Ethernet/ARP/IPv4/ICMP/UDP headers from a 64-bit AXI-Stream and emits
// one registered classification record per frame plus saturating statistics.
//
// state   | meaning
// IDLE    | waiting for beat 0 of a frame
// HDR     | beats 1..5, header fields being captured
// PAYLOAD | beats 6+, bytes counted only
module eth_rx_frame_classifier
    import eth_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h211abcdef112,
    parameter int          CNT_W     = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_axis_tvalid,
    input  logic [63:0]       i_axis_tdata,
    input  logic              i_axis_tlast,
    input  logic [7:0]        i_axis_tkeep,
    output logic              o_result_valid,
    output logic [2:0]        o_class,
    output logic              o_error,
    output logic              o_mac_match,
    output logic [47:0]       o_dst_mac,
    output logic [47:0]       o_src_mac,
    output logic [15:0]       o_ethertype,
    output logic [31:0]       o_src_ip,
    output logic [31:0]       o_dst_ip,
    output logic [15:0]       o_l4_dst_port,
    output logic [15:0]       o_byte_count,
    output logic [CNT_W-1:0]  o_arp_cnt,
    output logic [CNT_W-1:0]  o_icmp_cnt,
    output logic [CNT_W-1:0]  o_udp_cnt,
    output logic [CNT_W-1:0]  o_err_cnt
);

    rx_state_e   state_q, state_d;
    logic        capture_en;
    logic [3:0]  beat_q, beat_d;
    logic [15:0] acc_q;
    logic        keep_err_q, keep_err_d;
    logic [47:0] dst_mac_q, dst_mac_d, src_mac_q, src_mac_d;
    logic [15:0] ethertype_q, ethertype_d, udp_port_q, udp_port_d;
    logic [3:0]  ihl_q, ihl_d;
    logic [7:0]  proto_q, proto_d;
    logic [31:0] ip_src_q, ip_src_d, ip_dst_q, ip_dst_d, arp_sip_q, arp_sip_d, arp_tip_q, arp_tip_d;
    logic [3:0]  kd_pop;
    logic        kd_contig;
    logic [7:0]  bv [8];
    logic [16:0] byte_sum;
    logic [15:0] frame_bytes;
    logic        is_arp, is_ipv4, err_c, mac_match_c;
    eth_class_e  class_c;
    logic        beat_fire, frame_end;

    eth_keep_decode u_keep_decode (
        .tkeep_i    (i_axis_tkeep),
        .popcount_o (kd_pop),
        .contig_o   (kd_contig)
    );

    assign beat_fire = i_axis_tvalid;
    assign frame_end = i_axis_tvalid & i_axis_tlast;

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // FSM next state: tlast always returns to IDLE; header ends after beat 5.
    always_comb begin
        state_d = state_q;
        if (beat_fire) begin
            if (i_axis_tlast) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE:    state_d = ST_HDR;
                    ST_HDR:     state_d = (beat_q == 4'd5) ? ST_PAYLOAD : ST_HDR;
                    ST_PAYLOAD: state_d = ST_PAYLOAD;
                    default:    state_d = ST_IDLE;
                endcase
            end
        end
    end

    // FSM outputs: header bytes are only captured before the payload phase.
    always_comb begin
        capture_en = (state_q != ST_PAYLOAD);
    end

    // Split the beat into wire bytes, first wire byte in the low lane.
    always_comb begin
        for (int k = 0; k < 8; k++) bv[k] = i_axis_tdata[8*k +: 8];
    end

    // Header field capture keyed on beat index (wire byte = beat*8 + lane).
    always_comb begin
        dst_mac_d   = dst_mac_q;
        src_mac_d   = src_mac_q;
        ethertype_d = ethertype_q;
        ihl_d       = ihl_q;
        proto_d     = proto_q;
        ip_src_d    = ip_src_q;
        ip_dst_d    = ip_dst_q;
        udp_port_d  = udp_port_q;
        arp_sip_d   = arp_sip_q;
        arp_tip_d   = arp_tip_q;
        if (beat_fire && capture_en) begin
            case (beat_q)
                4'd0: begin
                    dst_mac_d         = {bv[0], bv[1], bv[2], bv[3], bv[4], bv[5]};
                    src_mac_d[47:32]  = {bv[6], bv[7]};
                end
                4'd1: begin
                    src_mac_d[31:0]   = {bv[0], bv[1], bv[2], bv[3]};
                    ethertype_d       = {bv[4], bv[5]};
                    ihl_d             = bv[6][3:0];
                end
                4'd2: proto_d = bv[7];
                4'd3: begin
                    ip_src_d          = {bv[2], bv[3], bv[4], bv[5]};
                    ip_dst_d[31:16]   = {bv[6], bv[7]};
                    arp_sip_d         = {bv[4], bv[5], bv[6], bv[7]};
                end
                4'd4: begin
                    ip_dst_d[15:0]    = {bv[0], bv[1]};
                    udp_port_d        = {bv[4], bv[5]};
                    arp_tip_d[31:16]  = {bv[6], bv[7]};
                end
                4'd5: arp_tip_d[15:0] = {bv[0], bv[1]};
                default: ;
            endcase
        end
    end

    // Running byte total, beat index and keep-error tracking for the current beat.
    always_comb begin
        byte_sum    = {1'b0, acc_q} + {13'd0, kd_pop};
        frame_bytes = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];
        beat_d      = (beat_q == 4'hF) ? beat_q : beat_q + 4'd1;
        keep_err_d  = keep_err_q | (!i_axis_tlast && (i_axis_tkeep != 8'hFF));
    end

    // Classification of the frame ending on this beat, using freshly captured fields.
    always_comb begin
        is_arp      = (ethertype_d == ETHERTYPE_ARP);
        is_ipv4     = (ethertype_d == ETHERTYPE_IPV4);
        mac_match_c = (dst_mac_d == LOCAL_MAC) || (dst_mac_d == BROADCAST_MAC);
        err_c       = keep_err_q || !kd_contig || (frame_bytes < MIN_ETH_BYTES) ||
                      ((is_arp || is_ipv4) && (frame_bytes < MIN_ARP_IP_BYTES));
        class_c     = CLASS_OTHER;
        if (err_c)                         class_c = CLASS_OTHER;
        else if (is_arp)                   class_c = CLASS_ARP;
        else if (is_ipv4 && ihl_d == 4'd5) begin
            if (proto_d == IP_PROTO_ICMP)     class_c = CLASS_ICMP;
            else if (proto_d == IP_PROTO_UDP) class_c = CLASS_UDP;
            else                              class_c = CLASS_IPV4_OTHER;
        end
        else if (is_ipv4)                  class_c = CLASS_IPV4_OTHER;
    end

    // Per-frame datapath state; idle cycles hold everything.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            beat_q      <= 4'd0;
            acc_q       <= 16'd0;
            keep_err_q  <= 1'b0;
            dst_mac_q   <= '0;
            src_mac_q   <= '0;
            ethertype_q <= '0;
            ihl_q       <= '0;
            proto_q     <= '0;
            ip_src_q    <= '0;
            ip_dst_q    <= '0;
            udp_port_q  <= '0;
            arp_sip_q   <= '0;
            arp_tip_q   <= '0;
        end else if (beat_fire) begin
            beat_q      <= i_axis_tlast ? 4'd0 : beat_d;
            acc_q       <= i_axis_tlast ? 16'd0 : frame_bytes;
            keep_err_q  <= i_axis_tlast ? 1'b0 : keep_err_d;
            dst_mac_q   <= dst_mac_d;
            src_mac_q   <= src_mac_d;
            ethertype_q <= ethertype_d;
            ihl_q       <= ihl_d;
            proto_q     <= proto_d;
            ip_src_q    <= ip_src_d;
            ip_dst_q    <= ip_dst_d;
            udp_port_q  <= udp_port_d;
            arp_sip_q   <= arp_sip_d;
            arp_tip_q   <= arp_tip_d;
        end
    end

    // Result record, loaded one cycle after the tlast beat and held until the next.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_result_valid <= 1'b0;
            o_class        <= 3'd0;
            o_error        <= 1'b0;
            o_mac_match    <= 1'b0;
            o_dst_mac      <= '0;
            o_src_mac      <= '0;
            o_ethertype    <= '0;
            o_src_ip       <= '0;
            o_dst_ip       <= '0;
            o_l4_dst_port  <= '0;
            o_byte_count   <= '0;
        end else begin
            o_result_valid <= frame_end;
            if (frame_end) begin
                o_class       <= class_c;
                o_error       <= err_c;
                o_mac_match   <= mac_match_c;
                o_dst_mac     <= dst_mac_d;
                o_src_mac     <= src_mac_d;
                o_ethertype   <= ethertype_d;
                o_src_ip      <= is_arp ? arp_sip_d : ip_src_d;
                o_dst_ip      <= is_arp ? arp_tip_d : ip_dst_d;
                o_l4_dst_port <= (class_c == CLASS_UDP) ? udp_port_d : 16'd0;
                o_byte_count  <= frame_bytes;
            end
        end
    end

    // Saturating statistics, updated from the result record while it is valid.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_arp_cnt  <= '0;
            o_icmp_cnt <= '0;
            o_udp_cnt  <= '0;
            o_err_cnt  <= '0;
        end else if (o_result_valid) begin
            if (o_error) begin
                if (~&o_err_cnt) o_err_cnt <= o_err_cnt + 1'b1;
            end else if (o_mac_match) begin
                if (o_class == CLASS_ARP  && ~&o_arp_cnt)  o_arp_cnt  <= o_arp_cnt + 1'b1;
                if (o_class == CLASS_ICMP && ~&o_icmp_cnt) o_icmp_cnt <= o_icmp_cnt + 1'b1;
                if (o_class == CLASS_UDP  && ~&o_udp_cnt)  o_udp_cnt  <= o_udp_cnt + 1'b1;
            end
        end
    end

endmodule
